seq_bit_serializer: RTL and testbench

- Upstream feeder for the 11x1 sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on o_seq, which drives the detector's i_seq.
- Supports gapless back-to-back words, so detector patterns may straddle word boundaries.
- o_seq_valid qualifies each bit for downstream consumers and monitors.

---
 rtl/seq_bit_serializer_if.sv | 11 +
 rtl/seq_bit_serializer.sv | 102 ++++++++++
 tb/tb_seq_bit_serializer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seq_bit_serializer_if.sv
// Valid/ready word handshake between a parallel word source and seq_bit_serializer.
interface seq_bit_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the 11x1 sequence detector, gapless back-to-back words.
// Optional even-parity trailer bit is enabled by defining SER_PARITY_EN.
module seq_bit_serializer #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_bit_serializer_if.slave in_if,
  output logic                o_seq,
  output logic                o_seq_valid,
  output logic                o_busy
);

`ifdef SER_PARITY_EN
  localparam int FL = DATA_W + 1;
`else
  localparam int FL = DATA_W;
`endif
  localparam int            CW   = $clog2(DATA_W + 2);
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_t;

  state_t        state, next_state;
  logic [FL-1:0] sr, frame;
  logic [CW-1:0] cnt;
  logic          ready, load, step, seq_d;

  function automatic logic head(input logic [FL-1:0] x);
    return (MSB_FIRST != 0) ? x[FL-1] : x[0];
  endfunction

  function automatic logic [FL-1:0] advance(input logic [FL-1:0] x);
    return (MSB_FIRST != 0) ? (x << 1) : (x >> 1);
  endfunction

  // The parity bit sits at the tail end of the frame, whichever direction the word is shifted.
`ifdef SER_PARITY_EN
  assign frame = (MSB_FIRST != 0) ? {in_if.i_data, ^in_if.i_data}
                                  : {^in_if.i_data, in_if.i_data};
`else
  assign frame = in_if.i_data;
`endif

  assign in_if.o_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = load ? SHIFT : IDLE;
      SHIFT:   next_state = (step || load) ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // In SHIFT, cnt is the index of the bit currently on o_seq, so the last bit opens the handshake.
  always_comb begin
    ready = 1'b0;
    step  = 1'b0;
    case (state)
      IDLE: ready = rst_n;
      SHIFT: begin
        ready = rst_n && (cnt == LAST);
        step  = (cnt != LAST);
      end
      default: ;
    endcase
    load  = ready && in_if.i_valid;
    seq_d = load ? head(frame) : (step ? head(sr) : 1'b0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= '0;
      cnt         <= '0;
      o_seq       <= 1'b0;
      o_seq_valid <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      if (load) begin
        sr  <= advance(frame);
        cnt <= '0;
      end else if (step) begin
        sr  <= advance(sr);
        cnt <= cnt + CW'(1);
      end
      o_seq       <= seq_d;
      o_seq_valid <= (next_state == SHIFT);
      o_busy      <= (next_state == SHIFT);
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: MSB-first and LSB-first instances share one stimulus stream
// and are compared every cycle against a queue-of-frame-bits reference model.
module tb_seq_bit_serializer;
  localparam int DATA_W = 4;
`ifdef SER_PARITY_EN
  localparam int FL = DATA_W + 1;
`else
  localparam int FL = DATA_W;
`endif

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] data  = '0;
  logic              valid = 1'b0;
  logic              msb_seq, msb_seq_valid, msb_busy;
  logic              lsb_seq, lsb_seq_valid, lsb_busy;

  int                n_checks = 0;
  int                n_fails  = 0;
  bit                msb_q[$];
  bit                lsb_q[$];
  bit                accepted = 1'b0;
  logic              rnd_valid = 1'b0;
  logic [DATA_W-1:0] rnd_word  = '0;

  always #5 clk = ~clk;

  seq_bit_serializer_if #(.DATA_W(DATA_W)) msb_if ();
  seq_bit_serializer_if #(.DATA_W(DATA_W)) lsb_if ();

  assign msb_if.i_data  = data;
  assign msb_if.i_valid = valid;
  assign lsb_if.i_data  = data;
  assign lsb_if.i_valid = valid;

  seq_bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(1)) dut_msb (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_if       (msb_if.slave),
    .o_seq       (msb_seq),
    .o_seq_valid (msb_seq_valid),
    .o_busy      (msb_busy)
  );

  seq_bit_serializer #(.DATA_W(DATA_W), .MSB_FIRST(0)) dut_lsb (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_if       (lsb_if.slave),
    .o_seq       (lsb_seq),
    .o_seq_valid (lsb_seq_valid),
    .o_busy      (lsb_busy)
  );

  // Frame bit idx of word w in transmission order; index DATA_W is the even-parity trailer.
  function automatic bit frame_bit(input logic [DATA_W-1:0] w, input int idx, input bit msb_first);
    if (idx >= DATA_W) return bit'($countones(w) % 2);
    return msb_first ? bit'(w[DATA_W-1-idx]) : bit'(w[idx]);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit mv, lv;
    mv = msb_q.size() > 0;
    lv = lsb_q.size() > 0;
    check("msb_seq_valid", msb_seq_valid, mv);
    check("msb_seq", msb_seq, mv ? msb_q[0] : 1'b0);
    check("msb_busy", msb_busy, mv);
    check("msb_ready", msb_if.o_ready, msb_q.size() <= 1);
    check("lsb_seq_valid", lsb_seq_valid, lv);
    check("lsb_seq", lsb_seq, lv ? lsb_q[0] : 1'b0);
    check("lsb_busy", lsb_busy, lv);
    check("lsb_ready", lsb_if.o_ready, lsb_q.size() <= 1);
  endtask

  task automatic checkReset();
    check("rst_msb_seq", msb_seq, 1'b0);
    check("rst_msb_seq_valid", msb_seq_valid, 1'b0);
    check("rst_msb_busy", msb_busy, 1'b0);
    check("rst_msb_ready", msb_if.o_ready, 1'b0);
    check("rst_lsb_seq", lsb_seq, 1'b0);
    check("rst_lsb_seq_valid", lsb_seq_valid, 1'b0);
    check("rst_lsb_busy", lsb_busy, 1'b0);
    check("rst_lsb_ready", lsb_if.o_ready, 1'b0);
  endtask

  // One clock: the word transfers when the model has at most the last bit still showing.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d);
    bit take_m, take_l;
    valid  = v;
    data   = d;
    take_m = v && (msb_q.size() <= 1);
    take_l = v && (lsb_q.size() <= 1);
    @(posedge clk);
    if (msb_q.size() > 0) void'(msb_q.pop_front());
    if (lsb_q.size() > 0) void'(lsb_q.pop_front());
    if (take_m) for (int i = 0; i < FL; i++) msb_q.push_back(frame_bit(d, i, 1'b1));
    if (take_l) for (int i = 0; i < FL; i++) lsb_q.push_back(frame_bit(d, i, 1'b0));
    accepted = take_m;
    #1;
    checkOutput();
  endtask

  task automatic sendWord(input logic [DATA_W-1:0] d);
    int waited;
    waited = 0;
    do begin
      applyStimulus(1'b1, d);
      waited++;
    end while (!accepted && waited < 4 * FL);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, DATA_W'($urandom));
  endtask

  initial begin
    #1 checkReset();
    repeat (2) @(posedge clk);
    #1 checkReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput();

    $display("[TB] single word 1101");
    sendWord(4'b1101);
    idle(FL + 2);

    $display("[TB] back-to-back 1101, 1111");
    sendWord(4'b1101);
    sendWord(4'b1111);
    idle(FL + 2);

    $display("[TB] word 1011");
    sendWord(4'b1011);
    idle(FL + 2);

    $display("[TB] reset mid-frame");
    sendWord(4'b1111);
    idle(1);
    #2 rst_n = 1'b0;
    #1 checkReset();
    msb_q.delete();
    lsb_q.delete();
    @(posedge clk);
    #1 checkReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 checkOutput();
    idle(FL + 2);

    $display("[TB] backpressure 1001 then held 0110");
    sendWord(4'b1001);
    sendWord(4'b0110);
    idle(FL + 2);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      if (!rnd_valid || accepted) begin
        rnd_valid = ($urandom_range(0, 3) != 0);
        rnd_word  = DATA_W'($urandom);
      end
      applyStimulus(rnd_valid, rnd_word);
    end
    idle(FL + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
